mouse_packet_assembler: RTL and testbench
=========================================

# mouse_packet_assembler

Assembles the 3-byte PS/2 mouse movement packet from a received byte stream, accumulates signed X/Y motion between video frames, and presents one saturated 8-bit delta pair plus button state per frame. It sits directly upstream of the cursor-position stage. That stage adds `Mouse_XDiff`/`Mouse_YDiff` to the cursor once per frame, so Y is delivered screen-oriented: positive means downward. Motion beyond ±127 per frame is carried over to later frames, not lost.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum idle cycles between bytes of one packet before resync.
- `ACC_W`, default 12: signed accumulator width per axis.
- `Clk` in 1: single clock for all state.
- `Reset` in 1: asynchronous, active-high reset.
- `Byte_Data` in 8: received PS/2 byte, valid when `Byte_Valid`=1.
- `Byte_Valid` in 1: single-cycle strobe, one per received byte.
- `Frame_Tick` in 1: single-cycle strobe, once per frame; drains the accumulators to the outputs.
- `Mouse_XDiff` out signed 8: X motion for the last frame, positive right.
- `Mouse_YDiff` out signed 8: Y motion for the last frame, positive down.
- `Buttons` out 8: {5'b0, middle, right, left}, taken from the latest complete packet.
- `Packet_Err` out 1: one-cycle pulse on sync error or inter-byte timeout.

## Operation
- **FSM states:** `WAIT_B0`, `WAIT_B1`, `WAIT_B2`. Each state advances only on `Byte_Valid`.
- **`WAIT_B0`:**
  - If `Byte_Data[3]`=0: drop the byte, pulse `Packet_Err`, stay in `WAIT_B0`.
  - Otherwise: store b0 and go to `WAIT_B1`.
- **`WAIT_B1`:** store b1 (X low byte), go to `WAIT_B2`.
- **`WAIT_B2`:** take b2 (Y low byte), commit the packet, go to `WAIT_B0`.
- **Commit arithmetic:**
  - dx = signed 9-bit {b0[4], b1}.
  - dy_raw = signed 9-bit {b0[5], b2}.
  - dy = −dy_raw, computed at 10 bits.
  - If b0[6] (X overflow) is set: dx = b0[4] ? −256 : +255.
  - If b0[7] (Y overflow) is set: dy_raw = b0[5] ? −256 : +255, then dy = −dy_raw.
  - The pending button register takes b0[2:0].
- **Accumulate:** acc_x += dx and acc_y += dy. Both are sign-extended to `ACC_W` and saturate at ±(2^(ACC_W−1)−1) or −2^(ACC_W−1).
- **Frame_Tick:**
  - out = clamp(acc, −128, +127).
  - `Mouse_XDiff`/`Mouse_YDiff` <= out.
  - acc <= acc − out, so the residue carries to the next frame.
  - `Buttons` <= pending button register.
- **Tick and commit in the same cycle:**
  - out is computed from acc before the commit.
  - acc <= sat(acc − out + d).
  - `Buttons` gets the pre-commit pending value; the new buttons appear on the next tick.
- **Timeout:**
  - An idle counter clears on every `Byte_Valid` and while in `WAIT_B0`.
  - In `WAIT_B1`/`WAIT_B2`, when the counter reaches `TIMEOUT_CYCLES`−1 with no byte: go to `WAIT_B0`, pulse `Packet_Err`, discard the partial packet.
  - A byte arriving in the same cycle the timeout expires wins: the byte is consumed and there is no error.
- **Outputs hold** their values between ticks.

## Timing
- **Reset values:** all outputs 0, state `WAIT_B0`, acc_x = acc_y = 0, pending buttons 0, idle counter 0.
- **Reset mid-packet:** discards the partial packet and both accumulators immediately (asynchronous).
- **Output latency:** registered outputs change on the clock edge that samples `Frame_Tick`=1 and are visible the following cycle.
- **Commit latency:** a packet committed on edge N is reflected at the earliest by a `Frame_Tick` sampled on edge N+1. When tick and commit share edge N, the rule under Operation applies.
- **`Packet_Err`:** registered; high for exactly the one cycle after the offending byte or timeout edge.
- **Flow control:** none. Every `Byte_Valid` is accepted and there is no backpressure.

## Structure
- **Package `mouse_pkg`:**
  - FSM state enum.
  - Button bit-index constants.
  - PS/2 b0 field positions (sync = 3, X sign = 4, Y sign = 5, X overflow = 6, Y overflow = 7).
  - Function `sat_to_s8` (clamp to −128..+127).
- **Sub-module `mouse_axis_acc`:** per-axis saturating accumulate, drain-on-tick and 8-bit output register. It is instantiated twice, for X and Y, and is parameterised by `ACC_W`.

## Test plan
- **Basic packet:** bytes 0x09, 0x05, 0x03, then tick → `Mouse_XDiff`=5, `Mouse_YDiff`=−3, `Buttons`=0x01, `Packet_Err` never high.
- **Sync error:** byte 0x00 → `Packet_Err` pulses 1 cycle, state stays `WAIT_B0`. Then 0x08, 0x02, 0x00 and tick → `Mouse_XDiff`=2.
- **Carry-over:** packets 0x08,0x64,0x00 twice (X=+200 total), then three ticks → `Mouse_XDiff` = 127, then 73, then 0.
- **Negative values:** 0x38,0xF0,0xF6 (X=−16, raw Y=−10), tick → `Mouse_XDiff`=−16, `Mouse_YDiff`=+10.
- **X overflow:** 0x48,0x10,0x00 → X=+255; ticks → 127, 127, 1.
- **Timeout and simultaneous tick:** 0x08,0x05 then `TIMEOUT_CYCLES` idle cycles → `Packet_Err` pulse, partial packet discarded. Then 0x0A,0x03,0x00 with `Frame_Tick` on the 0x00 cycle → that tick outputs `Mouse_XDiff`=0; the next tick outputs 3 with `Buttons`=0x02.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet assembler.
// Contents: the receive FSM state enum, button and b0 field bit positions,
// the stored b0 header layout, and the signed 8-bit clamp helper.
package mouse_pkg;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } mouse_state_e;

   // Button bit positions. These are the same in b0 and in Buttons.
   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_MIDDLE = 2;

   // PS/2 packet byte 0 field positions
   localparam int B0_SYNC  = 3;
   localparam int B0_XSIGN = 4;
   localparam int B0_YSIGN = 5;
   localparam int B0_XOVF  = 6;
   localparam int B0_YOVF  = 7;

   // The parts of b0 needed at commit time. The sync bit is checked on
   // arrival and is not kept.
   typedef struct packed {
      logic       y_ovf;
      logic       x_ovf;
      logic       y_sign;
      logic       x_sign;
      logic [2:0] btn;    // {middle, right, left}
   } b0_hdr_t;

   // Clamp a signed value to the range -128..+127
   function automatic logic signed [7:0] sat_to_s8(input logic signed [31:0] v);
      if (v > 32'sd127)
         return 8'sd127;
      else if (v < -32'sd128)
         return -8'sd128;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// Motion accumulator for a single axis.
// Each commit adds a signed 10-bit delta and saturates the result to ACC_W
// bits. Each tick drains the clamped 8-bit part of the accumulator into the
// output register and keeps the residue for later frames.
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   commit_i     : add d_i this cycle
//   d_i          : signed delta (-256..+256)
//   tick_i       : frame tick; drains the accumulator to diff_o
//   diff_o       : registered signed 8-bit motion for the last frame
module mouse_axis_acc
   import mouse_pkg::*;
#(
   parameter int ACC_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              commit_i,
   input  logic signed [9:0] d_i,
   input  logic              tick_i,
   output logic signed [7:0] diff_o
);

   // Two extra bits are enough headroom for acc - out + d before saturation
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {3'b111, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [7:0]       diff_q, diff_d;
   logic signed [7:0]       out_s8;
   logic signed [SW-1:0]    acc_ext, out_ext, d_ext, sum;

   always_comb begin
      // The drain amount always comes from the pre-commit accumulator
      out_s8  = sat_to_s8(32'(acc_q));
      acc_ext = {{2{acc_q[ACC_W-1]}}, acc_q};
      out_ext = tick_i   ? {{(SW-8){out_s8[7]}}, out_s8} : '0;
      d_ext   = commit_i ? {{(SW-10){d_i[9]}}, d_i}      : '0;
      sum     = acc_ext - out_ext + d_ext;

      if (sum > MAXV)
         acc_d = MAXV[ACC_W-1:0];
      else if (sum < MINV)
         acc_d = MINV[ACC_W-1:0];
      else
         acc_d = sum[ACC_W-1:0];

      diff_d = tick_i ? out_s8 : diff_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         diff_q <= '0;
      end else begin
         acc_q  <= acc_d;
         diff_q <= diff_d;
      end
   end

   assign diff_o = diff_q;

endmodule

// File: rtl/mouse_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets and turns them into per-frame cursor
// deltas. Y is negated so that positive means down on screen.
// Ports:
//   Clk, Reset     : clock and asynchronous active-high reset
//   Byte_Data/Valid: received PS/2 byte and its single-cycle strobe
//   Frame_Tick     : once per frame; updates the outputs from the accumulators
//   Mouse_XDiff    : signed X motion for the last frame (+ right)
//   Mouse_YDiff    : signed Y motion for the last frame (+ down)
//   Buttons        : {5'b0, middle, right, left} from the latest packet
//   Packet_Err     : one-cycle pulse on a sync error or an inter-byte timeout
module mouse_packet_assembler
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int ACC_W          = 12
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [7:0]        Byte_Data,
   input  logic              Byte_Valid,
   input  logic              Frame_Tick,
   output logic signed [7:0] Mouse_XDiff,
   output logic signed [7:0] Mouse_YDiff,
   output logic [7:0]        Buttons,
   output logic              Packet_Err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   mouse_state_e      state_q, state_d;
   b0_hdr_t           b0_q, b0_d;
   logic [7:0]        b1_q, b1_d;
   logic [CW-1:0]     idle_q, idle_d;
   logic              err_q, err_d;
   logic [2:0]        btn_pend_q, btn_pend_d;
   logic [2:0]        btn_q, btn_d;
   logic              commit;
   logic              timeout;
   logic signed [8:0] dx9, dy9;
   logic signed [9:0] dx10, dy10;

   // Commit arithmetic. b2 is taken straight from Byte_Data on the commit cycle.
   always_comb begin
      dx9 = {b0_q.x_sign, b1_q};
      if (b0_q.x_ovf)
         dx9 = b0_q.x_sign ? 9'h100 : 9'h0FF;
      dy9 = {b0_q.y_sign, Byte_Data};
      if (b0_q.y_ovf)
         dy9 = b0_q.y_sign ? 9'h100 : 9'h0FF;
      dx10 = {dx9[8], dx9};
      // Negating -256 gives +256, so this is done at 10 bits
      dy10 = -{dy9[8], dy9};
   end

   assign timeout = (idle_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      b0_d       = b0_q;
      b1_d       = b1_q;
      err_d      = 1'b0;
      commit     = 1'b0;
      idle_d     = (Byte_Valid || state_q == WAIT_B0) ? '0 : idle_q + 1'b1;

      case (state_q)
         WAIT_B0: begin
            if (Byte_Valid) begin
               if (!Byte_Data[B0_SYNC]) begin
                  err_d = 1'b1;
               end else begin
                  b0_d = '{y_ovf:  Byte_Data[B0_YOVF],
                           x_ovf:  Byte_Data[B0_XOVF],
                           y_sign: Byte_Data[B0_YSIGN],
                           x_sign: Byte_Data[B0_XSIGN],
                           btn:    {Byte_Data[BTN_MIDDLE], Byte_Data[BTN_RIGHT],
                                    Byte_Data[BTN_LEFT]}};
                  state_d = WAIT_B1;
               end
            end
         end
         WAIT_B1: begin
            if (Byte_Valid) begin
               b1_d    = Byte_Data;
               state_d = WAIT_B2;
            end else if (timeout) begin
               state_d = WAIT_B0;
               err_d   = 1'b1;
               idle_d  = '0;
            end
         end
         WAIT_B2: begin
            if (Byte_Valid) begin
               commit  = 1'b1;
               state_d = WAIT_B0;
            end else if (timeout) begin
               state_d = WAIT_B0;
               err_d   = 1'b1;
               idle_d  = '0;
            end
         end
         default: begin
            state_d = WAIT_B0;
            idle_d  = '0;
         end
      endcase

      btn_pend_d = commit ? b0_q.btn : btn_pend_q;
      // The tick takes the pre-commit pending buttons, so a packet that
      // commits on the same edge shows up on the following tick.
      btn_d      = Frame_Tick ? btn_pend_q : btn_q;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= WAIT_B0;
         b0_q       <= '0;
         b1_q       <= '0;
         idle_q     <= '0;
         err_q      <= 1'b0;
         btn_pend_q <= '0;
         btn_q      <= '0;
      end else begin
         state_q    <= state_d;
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         idle_q     <= idle_d;
         err_q      <= err_d;
         btn_pend_q <= btn_pend_d;
         btn_q      <= btn_d;
      end
   end

   mouse_axis_acc #(.ACC_W(ACC_W)) u_acc_x (
      .clk_i    (Clk),
      .rst_i    (Reset),
      .commit_i (commit),
      .d_i      (dx10),
      .tick_i   (Frame_Tick),
      .diff_o   (Mouse_XDiff)
   );

   mouse_axis_acc #(.ACC_W(ACC_W)) u_acc_y (
      .clk_i    (Clk),
      .rst_i    (Reset),
      .commit_i (commit),
      .d_i      (dy10),
      .tick_i   (Frame_Tick),
      .diff_o   (Mouse_YDiff)
   );

   assign Buttons    = {5'b0, btn_q};
   assign Packet_Err = err_q;

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// Scoreboard bench for mouse_packet_assembler. Stimulus queues the expected
// frame outputs and error-pulse cycles, and a negedge monitor checks them.
module tb_mouse_packet_assembler;

   localparam int T = 20;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic [7:0]        Byte_Data = 8'h00;
   logic              Byte_Valid = 1'b0;
   logic              Frame_Tick = 1'b0;
   logic signed [7:0] Mouse_XDiff, Mouse_YDiff;
   logic [7:0]        Buttons;
   logic              Packet_Err;

   mouse_packet_assembler #(.TIMEOUT_CYCLES(T), .ACC_W(12)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Byte_Data   (Byte_Data),
      .Byte_Valid  (Byte_Valid),
      .Frame_Tick  (Frame_Tick),
      .Mouse_XDiff (Mouse_XDiff),
      .Mouse_YDiff (Mouse_YDiff),
      .Buttons     (Buttons),
      .Packet_Err  (Packet_Err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int x;
      int y;
      int b;
   } exp_t;

   exp_t exp_q[$];
   int   err_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic tick_d = 1'b0;
   logic exp_err;
   exp_t cur;

   always @(posedge Clk) begin
      cyc    <= cyc + 1;
      tick_d <= Frame_Tick;
   end

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor. It compares the outputs one cycle after each sampled tick and
   // checks every cycle whether Packet_Err is high when expected.
   always @(negedge Clk) begin
      if (tick_d) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", 1, 0);
         end else begin
            cur = exp_q.pop_front();
            chk("xdiff",   int'(Mouse_XDiff), cur.x);
            chk("ydiff",   int'(Mouse_YDiff), cur.y);
            chk("buttons", int'(Buttons),     cur.b);
         end
      end
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      if (exp_err)
         void'(err_q.pop_front());
      if (exp_err || Packet_Err)
         chk("packet_err", int'(Packet_Err), int'(exp_err));
   end

   // Every task starts and ends on a negedge
   task automatic send(input logic [7:0] b);
      Byte_Data  = b;
      Byte_Valid = 1'b1;
      @(negedge Clk);
      Byte_Valid = 1'b0;
   endtask

   task automatic send_err(input logic [7:0] b);
      err_q.push_back(cyc + 1);
      send(b);
   endtask

   task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send(b0);
      send(b1);
      send(b2);
   endtask

   task automatic tick(input int x, input int y, input int b);
      exp_t e;
      e.x = x; e.y = y; e.b = b;
      exp_q.push_back(e);
      Frame_Tick = 1'b1;
      @(negedge Clk);
      Frame_Tick = 1'b0;
   endtask

   task automatic send_tick(input logic [7:0] byt, input int x, input int y, input int b);
      exp_t e;
      e.x = x; e.y = y; e.b = b;
      exp_q.push_back(e);
      Byte_Data  = byt;
      Byte_Valid = 1'b1;
      Frame_Tick = 1'b1;
      @(negedge Clk);
      Byte_Valid = 1'b0;
      Frame_Tick = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge Clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge Clk);
      chk("rst_xdiff",   int'(Mouse_XDiff), 0);
      chk("rst_ydiff",   int'(Mouse_YDiff), 0);
      chk("rst_buttons", int'(Buttons),     0);
      chk("rst_err",     int'(Packet_Err),  0);
      Reset = 1'b0;
      idle(2);

      // Basic packet, left button
      pkt(8'h09, 8'h05, 8'h03);
      tick(5, -3, 1);

      // Sync error, then a good packet
      send_err(8'h00);
      pkt(8'h08, 8'h02, 8'h00);
      tick(2, 0, 0);

      // Carry-over of +200
      pkt(8'h08, 8'h64, 8'h00);
      pkt(8'h08, 8'h64, 8'h00);
      tick(127, 0, 0);
      tick(73, 0, 0);
      tick(0, 0, 0);

      // Negative X and negative raw Y
      pkt(8'h38, 8'hF0, 8'hF6);
      tick(-16, 10, 0);

      // X overflow: +255
      pkt(8'h48, 8'h10, 8'h00);
      tick(127, 0, 0);
      tick(127, 0, 0);
      tick(1, 0, 0);

      // Y overflow, negative sign: raw -256 becomes +256 down
      pkt(8'hA8, 8'h00, 8'h00);
      tick(0, 127, 0);
      tick(0, 127, 0);
      tick(0, 2, 0);

      // Y overflow, positive sign: raw +255 becomes -255
      pkt(8'h88, 8'h00, 8'h00);
      tick(0, -128, 0);
      tick(0, -127, 0);

      // Inter-byte timeout discards the partial packet
      send(8'h08);
      err_q.push_back(cyc + 1 + T);
      send(8'h05);
      idle(T);
      idle(2);
      // Tick and commit on the same edge
      send(8'h0A);
      send(8'h03);
      send_tick(8'h00, 0, 0, 0);
      tick(3, 0, 2);

      // A byte that arrives on the timeout edge is consumed
      send(8'h08);
      idle(T - 1);
      send(8'h01);
      send(8'h00);
      tick(1, 0, 0);

      // Reset mid-packet clears the accumulators and the partial packet
      pkt(8'h08, 8'h7F, 8'h00);
      send(8'h08);
      #2 Reset = 1'b1;
      #1;
      chk("rst2_xdiff", int'(Mouse_XDiff), 0);
      chk("rst2_err",   int'(Packet_Err),  0);
      @(negedge Clk);
      Reset = 1'b0;
      idle(1);
      pkt(8'h08, 8'h01, 8'h00);
      tick(1, 0, 0);

      idle(4);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("err_q_drained", err_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
